uart_boot_loader: RTL and testbench
===================================

Name: uart_boot_loader

Overview:
- Bus initiator that drives the same store interface the memory/IO datapath responds to: address, wd, we, mem_ctrl.
- Consumes a framed byte stream from the UART receiver, packs payload bytes into words and issues stores into RAM.
- Checks an 8-bit checksum, holds the CPU core in reset until a frame completes cleanly, then releases it.
- Sits between the UART RX byte strobe and the datapath write port; it is muxed in front of the core's store signals while cpu_rst is high.

Parameters:
- MAX_LEN, 4096: largest accepted payload length in bytes; a longer length is a frame error.
- TIMEOUT_CYCLES, 1000000: maximum clk cycles allowed between bytes inside a frame before abort.
- HDR_BYTE, 8'hA5: frame start byte.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte, valid only when rx_valid=1
- rx_valid  in  1  one-cycle strobe per received byte; may be high on consecutive cycles
- address  out  32  store byte address to the datapath
- wd  out  32  store write data
- we  out  1  one-cycle store strobe
- mem_ctrl  out  3  store width code: shared STORE_W or STORE_B constant
- cpu_rst  out  1  core reset hold; 1 = core held
- done  out  1  last frame loaded with a good checksum
- error  out  1  last frame aborted or failed its checksum

Behaviour:
- Reset values: address=0, wd=0, we=0, mem_ctrl=STORE_W, cpu_rst=1, done=0, error=0. State goes to IDLE and all counters clear.
- Frame format:
  - HDR_BYTE.
  - LEN: 4 bytes, little-endian.
  - BASE: 4 bytes, little-endian.
  - LEN payload bytes.
  - 1 checksum byte, equal to the mod-256 sum of the payload bytes.
- States: IDLE, LEN, ADDR, DATA, CSUM, DONE, ERR.
- IDLE/DONE/ERR:
  - A byte equal to HDR_BYTE moves to LEN and clears byte counter, sum, done and error; cpu_rst=1.
  - Any other byte is ignored.
- LEN: after the 4th byte:
  - LEN>MAX_LEN -> ERR.
  - LEN=0 -> ADDR, then straight to CSUM after BASE.
- ADDR: after the 4th byte, BASE[1:0]!=0 -> ERR; otherwise go to DATA, or to CSUM if LEN=0.
- DATA, per byte: add it to the running sum and shift it into the pack register at lane offset[1:0], little-endian.
  - When a lane-3 byte completes a word: on the next cycle we=1, address=BASE+offset-3, wd=packed word, mem_ctrl=STORE_W.
  - Tail bytes (the last LEN%4 bytes): each byte issues its own store on the cycle after arrival, with we=1, address=BASE+offset, wd={24'b0,byte}, mem_ctrl=STORE_B.
  - After the last payload byte -> CSUM.
- Write latency: exactly 1 cycle after the completing rx_valid. we is high for exactly one cycle per store.
- Back-to-back bytes: byte acceptance never stalls. A new byte arriving in the same cycle as an issued store is captured; the store outputs come from a separate output register.
- CSUM: received byte == sum -> DONE (done=1, cpu_rst=0); mismatch -> ERR (error=1, cpu_rst stays 1). Stores already issued are not rolled back.
- Timeout: a counter clears on every rx_valid and runs only in LEN/ADDR/DATA/CSUM. Reaching TIMEOUT_CYCLES -> ERR. A pending store still issues.
- HDR_BYTE seen mid-frame is treated as data, not as a restart.
- rst mid-frame: any pending store is dropped (we=0 next edge), cpu_rst=1, state IDLE.
- offset wraps nothing: LEN<=MAX_LEN bounds it. Address arithmetic is 32-bit, modulo 2^32.

Decomposition:
- Shared control definitions package: STORE_B and STORE_W codes (already used by the datapath), plus the loader state encoding.
- One natural sub-module: boot_word_packer, which holds the lane shift, the running sum and the store output register, with its own we/addr/wd outputs.

Test Plan:
- Frame A5, LEN=8, BASE=0x100, payload 11 22 33 44 55 66 77 88, csum 0x64:
  - Expected stores: STORE_W 0x44332211 @0x100 and STORE_W 0x88776655 @0x104.
  - Then done=1, cpu_rst=0.
- LEN=6, BASE=0x200, payload 01..06:
  - Expected: one STORE_W 0x04030201 @0x200, then STORE_B 0x05 @0x204 and STORE_B 0x06 @0x205.
  - Each we is one cycle and lands one cycle after its byte.
- Good 4-byte frame with the checksum off by one: the store occurs, then error=1, done=0, cpu_rst stays 1. A following good frame gives done=1, error=0.
- LEN=MAX_LEN+1 -> ERR after the 4th LEN byte with no stores. BASE=0x102 -> ERR with no stores.
- Gap of TIMEOUT_CYCLES in DATA -> error=1. Bytes 00 7F before A5 in IDLE are ignored.
- rx_valid on 8 consecutive cycles -> two correct stores with no byte lost. rst asserted in DATA -> we=0, cpu_rst=1, IDLE.

Source files
------------

// File: rtl/uart_boot_loader_pkg.sv
// Store width codes shared with the memory/IO datapath, plus the loader's frame-parser states.
package uart_boot_loader_pkg;

   localparam logic [2:0] STORE_B = 3'b000;
   localparam logic [2:0] STORE_W = 3'b010;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_ADDR,
      ST_DATA,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } loader_state_t;

   // Multi-byte header fields arrive least significant byte first.
   function automatic logic [31:0] shift_in_le(input logic [31:0] cur, input logic [7:0] b);
      return {b, cur[31:8]};
   endfunction

endpackage

// File: rtl/uart_boot_loader_packer.sv
// Packs payload bytes into little-endian words, keeps the running checksum and
// owns the store output register so byte capture never waits on an issued store.
module boot_word_packer
   import uart_boot_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   input  logic [1:0]  lane,
   input  logic        tail,
   input  logic [31:0] store_addr,
   output logic        we,
   output logic [31:0] address,
   output logic [31:0] wd,
   output logic [2:0]  mem_ctrl,
   output logic [7:0]  sum
);

   logic        we_reg;
   logic [31:0] address_reg;
   logic [31:0] wd_reg;
   logic [2:0]  mem_ctrl_reg;
   logic [7:0]  sum_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_lane
         logic [7:0] lane_reg;
         always_ff @(posedge clk) begin
            if (rst) begin
               lane_reg <= '0;
            end else if (byte_valid && lane == 2'(gi)) begin
               lane_reg <= byte_data;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         we_reg       <= 1'b0;
         address_reg  <= '0;
         wd_reg       <= '0;
         mem_ctrl_reg <= STORE_W;
         sum_reg      <= '0;
      end else begin
         we_reg <= 1'b0;
         if (clear) begin
            sum_reg <= '0;
         end else if (byte_valid) begin
            sum_reg <= sum_reg + byte_data;
         end
         // Tail bytes never sit in lane 3, so the two store kinds are exclusive.
         if (byte_valid && tail) begin
            we_reg       <= 1'b1;
            address_reg  <= store_addr;
            wd_reg       <= {24'b0, byte_data};
            mem_ctrl_reg <= STORE_B;
         end else if (byte_valid && lane == 2'd3) begin
            we_reg       <= 1'b1;
            address_reg  <= store_addr;
            wd_reg       <= {byte_data, g_lane[2].lane_reg, g_lane[1].lane_reg, g_lane[0].lane_reg};
            mem_ctrl_reg <= STORE_W;
         end
      end
   end

   assign we       = we_reg;
   assign address  = address_reg;
   assign wd       = wd_reg;
   assign mem_ctrl = mem_ctrl_reg;
   assign sum      = sum_reg;

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: parses A5/LEN/BASE/payload/checksum frames, stores the payload
// into RAM and releases the core from reset once a frame loads cleanly.
module uart_boot_loader
   import uart_boot_loader_pkg::*;
#(
   parameter int          MAX_LEN        = 4096,
   parameter int          TIMEOUT_CYCLES = 1000000,
   parameter logic [7:0]  HDR_BYTE       = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [31:0] address,
   output logic [31:0] wd,
   output logic        we,
   output logic [2:0]  mem_ctrl,
   output logic        cpu_rst,
   output logic        done,
   output logic        error
);

   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

   loader_state_t state_reg;
   logic [1:0]    byte_cnt_reg;
   logic [31:0]   len_reg;
   logic [31:0]   base_reg;
   logic [31:0]   offset_reg;
   logic [TW-1:0] timer_reg;
   logic          done_reg;
   logic          error_reg;
   logic          cpu_rst_reg;

   logic [31:0] len_next;
   logic [31:0] base_next;
   logic        in_frame;
   logic        timeout_hit;
   logic        hdr_start;
   logic        data_valid;
   logic        tail;
   logic [31:0] store_addr;
   logic [7:0]  sum;

   assign len_next    = shift_in_le(len_reg, rx_data);
   assign base_next   = shift_in_le(base_reg, rx_data);
   assign in_frame    = (state_reg == ST_LEN) || (state_reg == ST_ADDR) ||
                        (state_reg == ST_DATA) || (state_reg == ST_CSUM);
   assign timeout_hit = in_frame && !rx_valid && (timer_reg == TW'(TIMEOUT_CYCLES - 1));
   assign hdr_start   = rx_valid && (rx_data == HDR_BYTE) &&
                        ((state_reg == ST_IDLE) || (state_reg == ST_DONE) || (state_reg == ST_ERR));
   assign data_valid  = rx_valid && (state_reg == ST_DATA);
   // The last LEN%4 bytes lie at or beyond the final whole-word boundary.
   assign tail        = offset_reg >= {len_reg[31:2], 2'b00};
   assign store_addr  = tail ? base_reg + offset_reg : base_reg + {offset_reg[31:2], 2'b00};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         byte_cnt_reg <= '0;
         len_reg      <= '0;
         base_reg     <= '0;
         offset_reg   <= '0;
         timer_reg    <= '0;
         done_reg     <= 1'b0;
         error_reg    <= 1'b0;
         cpu_rst_reg  <= 1'b1;
      end else begin
         if (rx_valid || !in_frame) begin
            timer_reg <= '0;
         end else begin
            timer_reg <= timer_reg + 1'b1;
         end

         case (state_reg)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (hdr_start) begin
                  state_reg    <= ST_LEN;
                  byte_cnt_reg <= '0;
                  offset_reg   <= '0;
                  done_reg     <= 1'b0;
                  error_reg    <= 1'b0;
                  cpu_rst_reg  <= 1'b1;
               end
            end
            ST_LEN: begin
               if (rx_valid) begin
                  len_reg      <= len_next;
                  byte_cnt_reg <= byte_cnt_reg + 1'b1;
                  if (byte_cnt_reg == 2'd3) begin
                     if (len_next > 32'(MAX_LEN)) begin
                        state_reg <= ST_ERR;
                        error_reg <= 1'b1;
                     end else begin
                        state_reg <= ST_ADDR;
                     end
                  end
               end
            end
            ST_ADDR: begin
               if (rx_valid) begin
                  base_reg     <= base_next;
                  byte_cnt_reg <= byte_cnt_reg + 1'b1;
                  if (byte_cnt_reg == 2'd3) begin
                     if (base_next[1:0] != 2'b00) begin
                        state_reg <= ST_ERR;
                        error_reg <= 1'b1;
                     end else if (len_reg == '0) begin
                        state_reg <= ST_CSUM;
                     end else begin
                        state_reg <= ST_DATA;
                     end
                  end
               end
            end
            ST_DATA: begin
               if (rx_valid) begin
                  offset_reg <= offset_reg + 32'd1;
                  if (offset_reg == len_reg - 32'd1) begin
                     state_reg <= ST_CSUM;
                  end
               end
            end
            ST_CSUM: begin
               if (rx_valid) begin
                  if (rx_data == sum) begin
                     state_reg   <= ST_DONE;
                     done_reg    <= 1'b1;
                     cpu_rst_reg <= 1'b0;
                  end else begin
                     state_reg <= ST_ERR;
                     error_reg <= 1'b1;
                  end
               end
            end
            default: state_reg <= ST_IDLE;
         endcase

         if (timeout_hit) begin
            state_reg <= ST_ERR;
            error_reg <= 1'b1;
         end
      end
   end

   boot_word_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear      (hdr_start),
      .byte_valid (data_valid),
      .byte_data  (rx_data),
      .lane       (offset_reg[1:0]),
      .tail       (tail),
      .store_addr (store_addr),
      .we         (we),
      .address    (address),
      .wd         (wd),
      .mem_ctrl   (mem_ctrl),
      .sum        (sum)
   );

   assign done    = done_reg;
   assign error   = error_reg;
   assign cpu_rst = cpu_rst_reg;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench: directed and random frames against a frame-level store model.
module tb_uart_boot_loader;
   import uart_boot_loader_pkg::*;

   localparam int         MAX_LEN = 64;
   localparam int         TMO     = 200;
   localparam logic [7:0] HDR     = 8'hA5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic [31:0] address;
   logic [31:0] wd;
   logic        we;
   logic [2:0]  mem_ctrl;
   logic        cpu_rst;
   logic        done;
   logic        error;

   uart_boot_loader #(
      .MAX_LEN        (MAX_LEN),
      .TIMEOUT_CYCLES (TMO),
      .HDR_BYTE       (HDR)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .address  (address),
      .wd       (wd),
      .we       (we),
      .mem_ctrl (mem_ctrl),
      .cpu_rst  (cpu_rst),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  ctrl;
      int          due;
   } store_t;

   store_t     exp_q[$];
   store_t     mon_e;
   logic [7:0] pl [0:127];

   // Every store must be expected, carry the modelled contents and land in its due cycle.
   always @(negedge clk) begin
      if (we === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_store", 32'(exp_q.size()), 32'd1);
         end else begin
            mon_e = exp_q.pop_front();
            $display("store addr=%h wd=%h ctrl=%0d cyc=%0d", address, wd, mem_ctrl, cyc);
            chk("store_addr", address, mon_e.addr);
            chk("store_wd", wd, mon_e.data);
            chk("store_ctrl", 32'(mem_ctrl), 32'(mon_e.ctrl));
            chk("store_cycle", 32'(cyc), 32'(mon_e.due));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] v, input int max_gap);
      for (int k = 0; k < 4; k++) begin
         send_byte(v[8*k +: 8]);
         idle($urandom_range(0, max_gap));
      end
   endtask

   task automatic chk_status(input logic exp_done, input logic exp_err, input logic exp_cpu_rst);
      chk("done", 32'(done), 32'(exp_done));
      chk("error", 32'(error), 32'(exp_err));
      chk("cpu_rst", 32'(cpu_rst), 32'(exp_cpu_rst));
   endtask

   // Model: payload byte i is part of word i/4 unless it is among the last len%4 bytes.
   task automatic send_frame(input int len, input logic [31:0] base, input logic [7:0] csum_err,
                             input int max_gap);
      logic [7:0] s;
      int         wlen;
      s    = 8'h00;
      wlen = (len / 4) * 4;
      send_byte(HDR);
      chk("hdr_clears_done", 32'(done), 32'd0);
      chk("hdr_holds_core", 32'(cpu_rst), 32'd1);
      idle($urandom_range(0, max_gap));
      send_word(32'(len), max_gap);
      send_word(base, max_gap);
      for (int i = 0; i < len; i++) begin
         send_byte(pl[i]);
         s = s + pl[i];
         if (i >= wlen) begin
            exp_q.push_back('{base + 32'(i), {24'b0, pl[i]}, STORE_B, cyc});
         end else if (i % 4 == 3) begin
            exp_q.push_back('{base + 32'(i - 3), {pl[i], pl[i-1], pl[i-2], pl[i-3]}, STORE_W, cyc});
         end
         idle($urandom_range(0, max_gap));
      end
      send_byte(s + csum_err);
      idle(2);
      $display("frame len=%0d base=%h csum_err=%0d done=%0b error=%0b", len, base, csum_err, done, error);
      chk_status(csum_err == 0, csum_err != 0, csum_err != 0);
      chk("stores_pending", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog cycles=%0d limit=expired", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int len;
      logic [7:0] cerr;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_address", address, 32'd0);
      chk("rst_wd", wd, 32'd0);
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_mem_ctrl", 32'(mem_ctrl), 32'(STORE_W));
      chk_status(1'b0, 1'b0, 1'b1);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Junk before the header is ignored; frame A is fully back-to-back.
      send_byte(8'h00);
      send_byte(8'h7F);
      chk_status(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) pl[i] = 8'((i + 1) * 8'h11);
      send_frame(8, 32'h100, 8'd0, 0);

      for (int i = 0; i < 6; i++) pl[i] = 8'(i + 1);
      send_frame(6, 32'h200, 8'd0, 0);

      for (int i = 0; i < 4; i++) pl[i] = 8'($urandom);
      send_frame(4, 32'h300, 8'd1, 2);
      send_frame(4, 32'h304, 8'd0, 1);

      // Oversized length aborts after the 4th LEN byte.
      send_byte(HDR);
      send_word(32'(MAX_LEN + 1), 0);
      idle(2);
      chk_status(1'b0, 1'b1, 1'b1);

      // Misaligned base aborts; payload bytes that follow are ignored.
      send_byte(HDR);
      send_word(32'd4, 0);
      send_word(32'h102, 0);
      idle(1);
      chk_status(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) send_byte(8'(8'h10 + i));
      idle(2);
      chk("err_discards", 32'(exp_q.size()), 32'd0);

      // Inter-byte gap just short of the limit survives; a full gap aborts.
      send_byte(HDR);
      send_word(32'd8, 0);
      send_word(32'h400, 0);
      send_byte(8'h01);
      send_byte(8'h02);
      idle(TMO - 3);
      chk("no_early_timeout", 32'(error), 32'd0);
      send_byte(8'h03);
      idle(TMO + 3);
      $display("timeout error=%0b", error);
      chk_status(1'b0, 1'b1, 1'b1);

      // Random frames, including empty and maximum lengths and mid-frame header bytes.
      for (int f = 0; f < 24; f++) begin
         case (f % 6)
            0:       len = 0;
            1:       len = MAX_LEN;
            default: len = $urandom_range(1, MAX_LEN);
         endcase
         for (int i = 0; i < len; i++) pl[i] = 8'($urandom);
         if ($urandom_range(0, 3) == 0 && len > 0) pl[$urandom_range(0, len - 1)] = HDR;
         cerr = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
         send_frame(len, $urandom & 32'hFFFF_FFFC, cerr, $urandom_range(0, 3));
      end

      // Reset in DATA coinciding with a word-completing byte drops that store.
      send_byte(HDR);
      send_word(32'd8, 0);
      send_word(32'h500, 0);
      send_byte(8'hB0);
      send_byte(8'hB1);
      send_byte(8'hB2);
      rx_data  = 8'hB3;
      rx_valid = 1'b1;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rst      = 1'b0;
      chk("rst_mid_we", 32'(we), 32'd0);
      chk_status(1'b0, 1'b0, 1'b1);
      send_byte(8'h44);
      idle(2);
      chk("idle_after_rst", 32'(exp_q.size()), 32'd0);
      for (int i = 0; i < 4; i++) pl[i] = 8'($urandom);
      send_frame(4, 32'h600, 8'd0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
